// File: rtl/sisc_dmem_responder.sv
// SISC data-memory responder: req/ack load/store port over an internal word array,
// with a fixed number of wait states before each one-cycle response.
module sisc_dmem_responder #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 16,
    parameter int DEPTH    = 256,
    parameter int WAIT_CYC = 2
) (
    input  logic              clk,
    input  logic              rst_f,
    input  logic              req,
    input  logic              we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata,
    output logic              ack,
    output logic              err,
    output logic              busy
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_WAIT = 2'd1;
    localparam logic [1:0] S_RESP = 2'd2;

    localparam int              MEM_AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [3:0]      WAIT_LD   = 4'(WAIT_CYC - 1);
    localparam logic [ADDR_W:0] DEPTH_LIM = (ADDR_W + 1)'(DEPTH);

    logic [1:0]        state;
    logic [3:0]        cnt;
    logic              we_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic [DATA_W-1:0] rdata_q;
    logic              in_range;
    logic [MEM_AW-1:0] mem_idx;
    logic [DATA_W-1:0] mem [DEPTH];

    assign in_range = ({1'b0, addr_q} < DEPTH_LIM);
    assign mem_idx  = addr_q[MEM_AW-1:0];

    always_ff @(posedge clk or negedge rst_f) begin
        if (!rst_f) begin
            state   <= S_IDLE;
            cnt     <= '0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (req) begin
                        we_q    <= we;
                        addr_q  <= addr;
                        wdata_q <= wdata;
                        if (WAIT_CYC > 0) begin
                            state <= S_WAIT;
                            cnt   <= WAIT_LD;
                        end else begin
                            state <= S_RESP;
                        end
                    end
                end
                S_WAIT: begin
                    if (cnt == '0) state <= S_RESP;
                    else           cnt   <= cnt - 4'd1;
                end
                S_RESP: begin
                    state   <= S_IDLE;
                    rdata_q <= rdata;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // Array has no reset; a reset during RESP leaves state != RESP so the write is dropped.
    always_ff @(posedge clk) begin
        if (state == S_RESP && we_q && in_range) mem[mem_idx] <= wdata_q;
    end

    assign ack  = (state == S_RESP);
    assign err  = ack && !in_range;
    assign busy = (state != S_IDLE);

    // Load data is shown combinationally in the ack cycle, then held in rdata_q.
    always_comb begin
        rdata = rdata_q;
        if (ack) begin
            if (!in_range)  rdata = '0;
            else if (!we_q) rdata = mem[mem_idx];
        end
    end

endmodule

// File: tb/tb_sisc_dmem_responder.sv
// Directed bench for sisc_dmem_responder: WAIT_CYC=2 instance plus a WAIT_CYC=0 instance.
module tb_sisc_dmem_responder;

    logic        clk = 1'b0;
    logic        rst_f = 1'b0;
    logic        a_req = 1'b0, a_we = 1'b0, b_req = 1'b0, b_we = 1'b0;
    logic [15:0] a_addr = '0, b_addr = '0;
    logic [31:0] a_wdata = '0, b_wdata = '0;
    logic [31:0] a_rdata, b_rdata;
    logic        a_ack, a_err, a_busy, b_ack, b_err, b_busy;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    sisc_dmem_responder #(.DATA_W(32), .ADDR_W(16), .DEPTH(256), .WAIT_CYC(2)) u_a (
        .clk(clk), .rst_f(rst_f), .req(a_req), .we(a_we), .addr(a_addr), .wdata(a_wdata),
        .rdata(a_rdata), .ack(a_ack), .err(a_err), .busy(a_busy)
    );

    sisc_dmem_responder #(.DATA_W(32), .ADDR_W(16), .DEPTH(256), .WAIT_CYC(0)) u_b (
        .clk(clk), .rst_f(rst_f), .req(b_req), .we(b_we), .addr(b_addr), .wdata(b_wdata),
        .rdata(b_rdata), .ack(b_ack), .err(b_err), .busy(b_busy)
    );

    // Issue one request; lat = posedges from raising req until ack is seen (99 = timeout).
    task automatic op(input bit sel, input logic w, input logic [15:0] ad, input logic [31:0] d,
                      output logic [31:0] rd, output logic er, output int lat);
        @(posedge clk); #1;
        if (sel) begin b_req = 1'b1; b_we = w; b_addr = ad; b_wdata = d; end
        else     begin a_req = 1'b1; a_we = w; a_addr = ad; a_wdata = d; end
        lat = 99; rd = '0; er = 1'b0;
        for (int i = 1; i <= 20; i++) begin
            @(posedge clk); #1;
            if (sel ? b_ack : a_ack) begin
                lat = i;
                rd  = sel ? b_rdata : a_rdata;
                er  = sel ? b_err : a_err;
                break;
            end
        end
        if (sel) b_req = 1'b0; else a_req = 1'b0;
    endtask

    task automatic test_reset();
        logic [31:0] rd; logic er; int lat; int spurious;
        tests++;
        if ({a_ack, a_err, a_busy} !== 3'b000 || a_rdata !== 32'h0) begin
            fails++;
            $display("FAIL reset_state: ack/err/busy=%b rdata=%h, expected 000 / 0", {a_ack, a_err, a_busy}, a_rdata);
        end
        op(1'b0, 1'b1, 16'h0010, 32'h55, rd, er, lat);
        @(posedge clk); #1;
        a_req = 1'b1; a_we = 1'b1; a_addr = 16'h0010; a_wdata = 32'hAA;
        @(posedge clk); #1;
        tests++;
        if (a_busy !== 1'b1) begin
            fails++; $display("FAIL reset_busy_before: busy=%b, expected 1", a_busy);
        end
        rst_f = 1'b0; #1;
        tests++;
        if ({a_ack, a_busy, a_err} !== 3'b000) begin
            fails++; $display("FAIL reset_async: ack/busy/err=%b, expected 000", {a_ack, a_busy, a_err});
        end
        a_req = 1'b0;
        #3 rst_f = 1'b1;
        spurious = 0;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            if (a_ack || a_busy) spurious++;
        end
        tests++;
        if (spurious !== 0) begin
            fails++; $display("FAIL reset_no_ack: %0d active cycles after release, expected 0", spurious);
        end
        op(1'b0, 1'b0, 16'h0010, 32'h0, rd, er, lat);
        tests++;
        if (rd !== 32'h55) begin
            fails++; $display("FAIL reset_dropped_write: rdata=%h, expected 00000055", rd);
        end
    endtask

    task automatic test_latency();
        logic [31:0] rd; logic er; int lat;
        op(1'b0, 1'b1, 16'h0004, 32'hDEADBEEF, rd, er, lat);
        tests++;
        if (lat !== 3 || er !== 1'b0) begin
            fails++; $display("FAIL write_latency: lat=%0d err=%b, expected 3 / 0", lat, er);
        end
        op(1'b0, 1'b0, 16'h0004, 32'h0, rd, er, lat);
        tests++;
        if (lat !== 3 || rd !== 32'hDEADBEEF || er !== 1'b0) begin
            fails++; $display("FAIL read_latency: lat=%0d rdata=%h err=%b, expected 3 / deadbeef / 0", lat, rd, er);
        end
        @(posedge clk); #1;
        tests++;
        if (a_rdata !== 32'hDEADBEEF || a_ack !== 1'b0) begin
            fails++; $display("FAIL rdata_hold: rdata=%h ack=%b, expected deadbeef / 0", a_rdata, a_ack);
        end
    endtask

    task automatic test_out_of_range();
        logic [31:0] rd; logic er; int lat;
        op(1'b0, 1'b1, 16'h00FF, 32'hCAFE00FF, rd, er, lat);
        op(1'b0, 1'b0, 16'h0100, 32'h0, rd, er, lat);
        tests++;
        if (er !== 1'b1 || rd !== 32'h0 || lat !== 3) begin
            fails++; $display("FAIL oor_read: err=%b rdata=%h lat=%0d, expected 1 / 0 / 3", er, rd, lat);
        end
        op(1'b0, 1'b1, 16'hFFFF, 32'h12345678, rd, er, lat);
        tests++;
        if (er !== 1'b1 || rd !== 32'h0 || lat !== 3) begin
            fails++; $display("FAIL oor_write: err=%b rdata=%h lat=%0d, expected 1 / 0 / 3", er, rd, lat);
        end
        op(1'b0, 1'b0, 16'h00FF, 32'h0, rd, er, lat);
        tests++;
        if (rd !== 32'hCAFE00FF || er !== 1'b0) begin
            fails++; $display("FAIL oor_no_alias: mem[ff]=%h err=%b, expected cafe00ff / 0", rd, er);
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] rd; logic er; int lat;
        int acks, last, bad_gap, wide, first;
        logic prev;
        @(posedge clk); #1;
        a_req = 1'b1; a_we = 1'b1; a_addr = 16'd0; a_wdata = 32'd1;
        acks = 0; last = 0; bad_gap = 0; wide = 0; first = 0; prev = 1'b0;
        for (int c = 1; c <= 40; c++) begin
            @(posedge clk); #1;
            if (a_ack) begin
                if (prev) wide++;
                if (acks == 0) first = c;
                else if (c - last != 4) bad_gap++;
                last = c;
                acks++;
                if (acks < 4) begin
                    a_addr = 16'(acks); a_wdata = 32'(acks + 1);
                end else begin
                    a_req = 1'b0;
                end
            end
            prev = a_ack;
        end
        a_req = 1'b0;
        tests++;
        if (acks !== 4 || first !== 3 || bad_gap !== 0 || wide !== 0) begin
            fails++;
            $display("FAIL b2b_acks: acks=%0d first=%0d bad_gaps=%0d wide=%0d, expected 4 / 3 / 0 / 0", acks, first, bad_gap, wide);
        end
        for (int i = 0; i < 4; i++) begin
            op(1'b0, 1'b0, 16'(i), 32'h0, rd, er, lat);
            tests++;
            if (rd !== 32'(i + 1)) begin
                fails++; $display("FAIL b2b_readback[%0d]: rdata=%h, expected %h", i, rd, 32'(i + 1));
            end
        end
    endtask

    task automatic test_zero_wait();
        logic [31:0] rd; logic er; int lat; int busy_cyc;
        op(1'b1, 1'b1, 16'h0002, 32'h22222222, rd, er, lat);
        tests++;
        if (lat !== 1) begin
            fails++; $display("FAIL zw_write_latency: lat=%0d, expected 1", lat);
        end
        @(posedge clk); #1;
        b_req = 1'b1; b_we = 1'b0; b_addr = 16'h0002;
        busy_cyc = 0; lat = 99; rd = '0;
        for (int i = 1; i <= 5; i++) begin
            @(posedge clk); #1;
            if (b_busy) busy_cyc++;
            if (b_ack && lat == 99) begin lat = i; rd = b_rdata; end
            b_req = 1'b0;
        end
        tests++;
        if (lat !== 1 || rd !== 32'h22222222 || busy_cyc !== 1) begin
            fails++;
            $display("FAIL zw_read: lat=%0d rdata=%h busy_cycles=%0d, expected 1 / 22222222 / 1", lat, rd, busy_cyc);
        end
    endtask

    task automatic test_capture_hold();
        logic [31:0] rd; logic er; int lat;
        op(1'b0, 1'b1, 16'h0006, 32'h66666666, rd, er, lat);
        @(posedge clk); #1;
        a_req = 1'b1; a_we = 1'b1; a_addr = 16'h0005; a_wdata = 32'h11111111;
        @(posedge clk); #1;
        a_addr = 16'h0006; a_wdata = 32'h22222222;
        lat = 99;
        for (int i = 2; i <= 20; i++) begin
            @(posedge clk); #1;
            if (a_ack) begin lat = i; break; end
        end
        a_req = 1'b0;
        tests++;
        if (lat !== 3) begin
            fails++; $display("FAIL hold_latency: lat=%0d, expected 3", lat);
        end
        op(1'b0, 1'b0, 16'h0005, 32'h0, rd, er, lat);
        tests++;
        if (rd !== 32'h11111111) begin
            fails++; $display("FAIL hold_addr5: rdata=%h, expected 11111111", rd);
        end
        op(1'b0, 1'b0, 16'h0006, 32'h0, rd, er, lat);
        tests++;
        if (rd !== 32'h66666666) begin
            fails++; $display("FAIL hold_addr6: rdata=%h, expected 66666666", rd);
        end
    endtask

    initial begin
        #2;
        test_reset();
        test_latency();
        test_out_of_range();
        test_back_to_back();
        test_zero_wait();
        test_capture_hold();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #1;
        rst_f = 1'b0;
        #12 rst_f = 1'b1;
    end

endmodule
